// File: rtl/dmem_arbiter.sv
// Two-requester front end for a single-port data memory: arbitration with port-1 anti-starvation,
// alignment checking, byte-lane steering and a one-cycle registered response path.
module dmem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_p0_req,
    input  logic        i_p0_we,
    input  logic [1:0]  i_p0_size,
    input  logic        i_p0_uns,
    input  logic [31:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    output logic        o_p0_gnt,
    output logic        o_p0_rvalid,
    output logic [31:0] o_p0_rdata,
    output logic        o_p0_err,
    input  logic        i_p1_req,
    input  logic        i_p1_we,
    input  logic [1:0]  i_p1_size,
    input  logic        i_p1_uns,
    input  logic [31:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    output logic        o_p1_gnt,
    output logic        o_p1_rvalid,
    output logic [31:0] o_p1_rdata,
    output logic        o_p1_err,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_be,
    output logic        o_mem_we,
    output logic        o_mem_re,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);

    typedef enum logic {OWNER_P0, OWNER_P1} owner_t;

    logic [3:0]  r_starveCnt;
    logic        r_rspValid;
    owner_t      r_rspOwner;
    logic        r_rspWe;
    logic [1:0]  r_rspSize;
    logic        r_rspUns;
    logic [1:0]  r_rspOff;
    logic        r_rspErr;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_grant;
    logic        w_selWe;
    logic [1:0]  w_selSize;
    logic        w_selUns;
    logic [31:0] w_selAddr;
    logic [31:0] w_selWdata;
    logic        w_fault;
    logic [31:0] w_shifted;
    logic [31:0] w_loadData;
    logic [31:0] w_rspData;
    logic        w_rspLive;

    // Port 0 wins ties until port 1 has watched MAX_BURST port-0 grants go by.
    always_comb begin
        w_gnt1     = ~i_rst & i_p1_req & (~i_p0_req | (r_starveCnt == LP_MAX_BURST));
        w_gnt0     = ~i_rst & i_p0_req & ~w_gnt1;
        w_grant    = w_gnt0 | w_gnt1;
        w_selWe    = w_gnt1 ? i_p1_we    : i_p0_we;
        w_selSize  = w_gnt1 ? i_p1_size  : i_p0_size;
        w_selUns   = w_gnt1 ? i_p1_uns   : i_p0_uns;
        w_selAddr  = w_gnt1 ? i_p1_addr  : i_p0_addr;
        w_selWdata = w_gnt1 ? i_p1_wdata : i_p0_wdata;
        w_fault    = ((w_selSize == 2'b01) & w_selAddr[0]) |
                     ((w_selSize == 2'b10) & (w_selAddr[1:0] != 2'b00)) |
                     (w_selSize == 2'b11);
    end

    assign o_p0_gnt = w_gnt0;
    assign o_p1_gnt = w_gnt1;

    // Faulting accesses are granted but never reach the memory.
    always_comb begin
        o_mem_addr  = 32'h0;
        o_mem_wdata = 32'h0;
        o_mem_be    = 4'h0;
        o_mem_we    = 1'b0;
        o_mem_re    = 1'b0;
        if (w_grant && !w_fault) begin
            o_mem_addr = {w_selAddr[31:2], 2'b00};
            if (w_selWe) begin
                o_mem_we = 1'b1;
                case (w_selSize)
                    2'b00: begin
                        o_mem_be    = 4'b0001 << w_selAddr[1:0];
                        o_mem_wdata = {4{w_selWdata[7:0]}};
                    end
                    2'b01: begin
                        o_mem_be    = 4'b0011 << w_selAddr[1:0];
                        o_mem_wdata = {2{w_selWdata[15:0]}};
                    end
                    default: begin
                        o_mem_be    = 4'hF;
                        o_mem_wdata = w_selWdata;
                    end
                endcase
            end else begin
                o_mem_re = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starveCnt <= 4'd0;
            r_rspValid  <= 1'b0;
            r_rspOwner  <= OWNER_P0;
            r_rspWe     <= 1'b0;
            r_rspSize   <= 2'b00;
            r_rspUns    <= 1'b0;
            r_rspOff    <= 2'b00;
            r_rspErr    <= 1'b0;
        end else begin
            if (!i_p1_req || w_gnt1) begin
                r_starveCnt <= 4'd0;
            end else if (w_gnt0 && (r_starveCnt != LP_MAX_BURST)) begin
                r_starveCnt <= r_starveCnt + 4'd1;
            end
            r_rspValid <= w_grant;
            r_rspOwner <= w_gnt1 ? OWNER_P1 : OWNER_P0;
            r_rspWe    <= w_selWe;
            r_rspSize  <= w_selSize;
            r_rspUns   <= w_selUns;
            r_rspOff   <= w_selAddr[1:0];
            r_rspErr   <= w_fault;
        end
    end

    // Memory data arrives the cycle after the grant; steer the addressed lane down and extend it.
    always_comb begin
        w_shifted = i_mem_rdata >> {r_rspOff, 3'b000};
        case (r_rspSize)
            2'b00:   w_loadData = {{24{~r_rspUns & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_loadData = {{16{~r_rspUns & w_shifted[15]}}, w_shifted[15:0]};
            default: w_loadData = i_mem_rdata;
        endcase
        w_rspData   = (r_rspWe || r_rspErr) ? 32'h0 : w_loadData;
        w_rspLive   = r_rspValid & ~i_rst;
        o_p0_rvalid = w_rspLive & (r_rspOwner == OWNER_P0);
        o_p1_rvalid = w_rspLive & (r_rspOwner == OWNER_P1);
        o_p0_err    = o_p0_rvalid & r_rspErr;
        o_p1_err    = o_p1_rvalid & r_rspErr;
        o_p0_rdata  = o_p0_rvalid ? w_rspData : 32'h0;
        o_p1_rdata  = o_p1_rvalid ? w_rspData : 32'h0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a randomized run
// compared against a behavioural model of arbitration, lane steering and load extension.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p0_uns, p1_req, p1_we, p1_uns;
    logic [1:0]  p0_size, p1_size;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_we, mem_re;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_p0_req(p0_req), .i_p0_we(p0_we), .i_p0_size(p0_size), .i_p0_uns(p0_uns),
        .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
        .o_p0_gnt(p0_gnt), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
        .i_p1_req(p1_req), .i_p1_we(p1_we), .i_p1_size(p1_size), .i_p1_uns(p1_uns),
        .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
        .o_p1_gnt(p1_gnt), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_be(mem_be),
        .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit port, input bit req, input bit we, input logic [1:0] size,
                                 input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            p0_req = req; p0_we = we; p0_size = size; p0_uns = uns; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_size = size; p1_uns = uns; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // Extends a loaded byte/half by arithmetic on its numeric value.
    function automatic logic [31:0] extend(input logic [31:0] raw, input int off, input int size, input bit uns);
        longint v;
        longint span;
        if (size == 2) return raw;
        span = (size == 0) ? 256 : 65536;
        v = (longint'(raw) >> (8 * off)) % span;
        if (!uns && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    task automatic test_reset();
        applyStimulus(0, 1, 1, 2'b10, 0, 32'h40, 32'h1234_5678);
        applyStimulus(1, 1, 0, 2'b10, 0, 32'h80, 32'h0);
        nextCycle();
        @(negedge clk);
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL rst_gnt: got %b%b expected 00", p0_gnt, p1_gnt); end
        checks++; if ({mem_we, mem_re, mem_be} !== 6'b0) begin errors++; $display("[TB] FAIL rst_memctl: got we=%b re=%b be=%h expected 0", mem_we, mem_re, mem_be); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_memdata: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata); end
        checks++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0) begin errors++; $display("[TB] FAIL rst_rsp: got rv=%b%b err=%b%b expected 0", p0_rvalid, p1_rvalid, p0_err, p1_err); end
        p0_req = 0; p1_req = 0;
        nextCycle();
        rst = 0;
        nextCycle();
    endtask

    task automatic test_load_word();
        applyStimulus(0, 1, 0, 2'b10, 0, 32'h100, 32'h0);
        mem_rdata = 32'h0;
        @(negedge clk);
        checks++; if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0) begin errors++; $display("[TB] FAIL lw_gnt: got %b%b expected 10", p0_gnt, p1_gnt); end
        checks++; if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'h0) begin errors++; $display("[TB] FAIL lw_memctl: got re=%b we=%b be=%h expected re=1 we=0 be=0", mem_re, mem_we, mem_be); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL lw_addr: got %h expected 00000100", mem_addr); end
        nextCycle();
        p0_req = 0;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (p0_rvalid !== 1'b1 || p0_err !== 1'b0 || p1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL lw_rvalid: got rv0=%b err0=%b rv1=%b expected 1 0 0", p0_rvalid, p0_err, p1_rvalid); end
        checks++; if (p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL lw_rdata: got %h expected deadbeef", p0_rdata); end
        nextCycle();
    endtask

    task automatic test_store_byte();
        applyStimulus(1, 1, 1, 2'b00, 0, 32'h103, 32'h1234_56A5);
        @(negedge clk);
        checks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin errors++; $display("[TB] FAIL sb_gnt: got %b%b expected 01", p0_gnt, p1_gnt); end
        checks++; if (mem_be !== 4'b1000 || mem_we !== 1'b1 || mem_re !== 1'b0) begin errors++; $display("[TB] FAIL sb_memctl: got be=%b we=%b re=%b expected 1000 1 0", mem_be, mem_we, mem_re); end
        checks++; if (mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h100) begin errors++; $display("[TB] FAIL sb_data: got wdata=%h addr=%h expected a5a5a5a5 00000100", mem_wdata, mem_addr); end
        nextCycle();
        p1_req = 0;
        mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (p1_rvalid !== 1'b1 || p1_err !== 1'b0 || p1_rdata !== 32'h0 || p0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL sb_rsp: got rv1=%b err1=%b rdata1=%h rv0=%b expected 1 0 0 0", p1_rvalid, p1_err, p1_rdata, p0_rvalid); end
        nextCycle();
    endtask

    task automatic test_load_half();
        logic [31:0] want;
        for (int u = 0; u < 2; u++) begin
            want = (u == 0) ? 32'hFFFF_8001 : 32'h0000_8001;
            applyStimulus(0, 1, 0, 2'b01, u[0], 32'h102, 32'h0);
            @(negedge clk);
            checks++; if (p0_gnt !== 1'b1 || mem_re !== 1'b1) begin errors++; $display("[TB] FAIL lh_gnt: got gnt=%b re=%b expected 1 1", p0_gnt, mem_re); end
            nextCycle();
            p0_req = 0;
            mem_rdata = 32'h8001_0000;
            @(negedge clk);
            checks++; if (p0_rvalid !== 1'b1 || p0_rdata !== want) begin errors++; $display("[TB] FAIL lh_rdata uns=%0d: got rv=%b %h expected 1 %h", u, p0_rvalid, p0_rdata, want); end
            nextCycle();
        end
    endtask

    task automatic test_starvation();
        bit e1;
        applyStimulus(0, 1, 0, 2'b10, 0, 32'h200, 32'h0);
        applyStimulus(1, 1, 0, 2'b10, 0, 32'h300, 32'h0);
        for (int i = 0; i < 10; i++) begin
            e1 = ((i % (MAX_BURST + 1)) == MAX_BURST);
            @(negedge clk);
            checks++; if (p1_gnt !== e1 || p0_gnt !== !e1) begin errors++; $display("[TB] FAIL burst_gnt cycle %0d: got %b%b expected %b%b", i, p0_gnt, p1_gnt, !e1, e1); end
            nextCycle();
        end
        p0_req = 0; p1_req = 0;
        nextCycle();
    endtask

    task automatic test_misaligned();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) applyStimulus(0, 1, 0, 2'b10, 0, 32'h101, 32'h0);
            else        applyStimulus(0, 1, 0, 2'b11, 0, 32'h100, 32'h0);
            @(negedge clk);
            checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL mis_gnt %0d: got %b expected 1", k, p0_gnt); end
            checks++; if ({mem_re, mem_we, mem_be} !== 6'b0) begin errors++; $display("[TB] FAIL mis_memctl %0d: got re=%b we=%b be=%h expected 0", k, mem_re, mem_we, mem_be); end
            nextCycle();
            p0_req = 0;
            mem_rdata = 32'h1357_9BDF;
            @(negedge clk);
            checks++; if (p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mis_rsp %0d: got rv=%b err=%b rdata=%h expected 1 1 0", k, p0_rvalid, p0_err, p0_rdata); end
            nextCycle();
        end
    endtask

    task automatic test_reset_mid();
        bit e1;
        applyStimulus(0, 1, 0, 2'b10, 0, 32'h200, 32'h0);
        applyStimulus(1, 1, 1, 2'b10, 0, 32'h300, 32'h55);
        @(negedge clk);
        checks++; if (p0_gnt !== 1'b1) begin errors++; $display("[TB] FAIL rmid_gnt: got %b expected 1", p0_gnt); end
        nextCycle();
        rst = 1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++; if (p0_rvalid !== 1'b0 || p0_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rmid_rvalid: got rv=%b rdata=%h expected 0 0", p0_rvalid, p0_rdata); end
        checks++; if ({p0_gnt, p1_gnt, mem_re, mem_we, mem_be} !== 8'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rmid_mem: got gnt=%b%b re=%b we=%b be=%h addr=%h wdata=%h expected 0", p0_gnt, p1_gnt, mem_re, mem_we, mem_be, mem_addr, mem_wdata); end
        nextCycle();
        rst = 0;
        for (int i = 0; i <= MAX_BURST; i++) begin
            e1 = (i == MAX_BURST);
            @(negedge clk);
            checks++; if (p1_gnt !== e1 || p0_gnt !== !e1) begin errors++; $display("[TB] FAIL rmid_starve cycle %0d: got %b%b expected %b%b", i, p0_gnt, p1_gnt, !e1, e1); end
            nextCycle();
        end
        p0_req = 0; p1_req = 0;
        nextCycle();
    endtask

    task automatic test_random();
        int waitCnt;
        bit e0, e1, fault, go, sWe, sUns;
        logic [1:0] sSize;
        logic [31:0] sAddr, sWdata, exBe, exWdata, exData;
        bit pValid, pOwner, pWe, pErr, pUns;
        int pSize, pOff;
        waitCnt = 0; pValid = 0; pOwner = 0; pWe = 0; pErr = 0; pUns = 0; pSize = 0; pOff = 0;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom, $urandom);
            applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom, $urandom);
            mem_rdata = $urandom;
            @(negedge clk);
            e1 = !rst && p1_req && (!p0_req || waitCnt == MAX_BURST);
            e0 = !rst && p0_req && !e1;
            sWe = e1 ? p1_we : p0_we;   sSize = e1 ? p1_size : p0_size;   sUns = e1 ? p1_uns : p0_uns;
            sAddr = e1 ? p1_addr : p0_addr;   sWdata = e1 ? p1_wdata : p0_wdata;
            fault = (sSize == 3) || (sSize == 1 && sAddr % 2 != 0) || (sSize == 2 && sAddr % 4 != 0);
            go = (e0 || e1) && !fault;
            exBe = (sSize == 0) ? 1 : (sSize == 1) ? 3 : 15;
            exBe = (go && sWe) ? ((exBe << (sAddr % 4)) & 15) : 0;
            exWdata = (sSize == 0) ? (sWdata % 256) * 32'h0101_0101 :
                      (sSize == 1) ? (sWdata % 65536) * 32'h0001_0001 : sWdata;
            exData = (pValid && !pWe && !pErr) ? extend(mem_rdata, pOff, pSize, pUns) : 32'h0;
            checks++; if (p0_gnt !== e0 || p1_gnt !== e1) begin errors++; $display("[TB] FAIL rnd_gnt cycle %0d: got %b%b expected %b%b", c, p0_gnt, p1_gnt, e0, e1); end
            checks++; if (mem_we !== (go && sWe) || mem_re !== (go && !sWe) || mem_be !== exBe[3:0]) begin errors++; $display("[TB] FAIL rnd_memctl cycle %0d: got we=%b re=%b be=%h expected %b %b %h", c, mem_we, mem_re, mem_be, go && sWe, go && !sWe, exBe[3:0]); end
            if (go) begin
                checks++; if (mem_addr !== (sAddr & 32'hFFFF_FFFC)) begin errors++; $display("[TB] FAIL rnd_addr cycle %0d: got %h expected %h", c, mem_addr, sAddr & 32'hFFFF_FFFC); end
            end
            if (go && sWe) begin
                checks++; if (mem_wdata !== exWdata) begin errors++; $display("[TB] FAIL rnd_wdata cycle %0d: got %h expected %h", c, mem_wdata, exWdata); end
            end
            if (!(e0 || e1)) begin
                checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rnd_idle cycle %0d: got addr=%h wdata=%h expected 0", c, mem_addr, mem_wdata); end
            end
            checks++; if (p0_rvalid !== (pValid && !rst && !pOwner) || p1_rvalid !== (pValid && !rst && pOwner)) begin errors++; $display("[TB] FAIL rnd_rvalid cycle %0d: got %b%b expected %b%b", c, p0_rvalid, p1_rvalid, pValid && !rst && !pOwner, pValid && !rst && pOwner); end
            checks++; if (p0_err !== (pValid && !rst && !pOwner && pErr) || p1_err !== (pValid && !rst && pOwner && pErr)) begin errors++; $display("[TB] FAIL rnd_err cycle %0d: got %b%b", c, p0_err, p1_err); end
            checks++; if (p0_rdata !== ((pValid && !rst && !pOwner) ? exData : 32'h0) || p1_rdata !== ((pValid && !rst && pOwner) ? exData : 32'h0)) begin errors++; $display("[TB] FAIL rnd_rdata cycle %0d: got %h %h expected %h on port %0d", c, p0_rdata, p1_rdata, exData, pOwner); end
            pValid = e0 || e1;  pOwner = e1;  pWe = sWe;  pErr = fault;  pUns = sUns;
            pSize = int'(sSize);  pOff = int'(sAddr % 4);
            // Count of consecutive port-0 wins that port 1 has sat through.
            if (rst || !p1_req || e1) waitCnt = 0;
            else if (e0 && waitCnt < MAX_BURST) waitCnt++;
            nextCycle();
        end
        rst = 0; p0_req = 0; p1_req = 0;
        nextCycle();
    endtask

    initial begin
        rst = 1;
        applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 0, 2'b00, 0, 32'h0, 32'h0);
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_word();
        test_store_byte();
        test_load_half();
        test_starvation();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
